sort_bitonic_pipe: RTL and testbench
====================================

// Module: sort_bitonic_pipe
// PURPOSE
//  Parametrised, fully pipelined bitonic sorting network: sorts one vector of 2**LOG_N unsigned or
//  signed W-bit keys per cycle, ascending or descending selectable per vector.
//  Adds valid/ready flow control with whole-pipe stall, plus a user tag carried alongside each vector.
//  Successor to the fixed 32x16b combinational sorters; sits between a streaming producer and consumer.
// PARAMETERS
//  LOG_N   5   log2 of element count; N = 2**LOG_N, legal 1..6
//  W       16  key width in bits, legal 1..64
//  SIGNED  0   1: keys compared as two's complement; 0: unsigned
//  TAG_W   8   width of user tag passed through unchanged, legal 1..32
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous active-high reset
//  in_valid   in   1      input vector valid
//  in_ready   out  1      block accepts input this cycle
//  in_desc    in   1      1: sort descending, 0: ascending; sampled with vector
//  in_tag     in   TAG_W  user tag, sampled with vector
//  data_in    in   N*W    element k at data_in[k*W +: W]
//  out_valid  out  1      output vector valid
//  out_ready  in   1      consumer accepts output this cycle
//  out_tag    out  TAG_W  tag of vector on data_out
//  data_out   out  N*W    sorted vector, element k at data_out[k*W +: W]
// BEHAVIOUR
//  - Network: standard bitonic, S = LOG_N*(LOG_N+1)/2 compare-exchange stages (S=15 default);
//    each stage holds N/2 compare-exchange units; every stage output is registered.
//  - Each stage register holds {valid, desc, tag, N*W data}; desc and tag travel with the data.
//  - Ascending: data_out element 0 = minimum, element N-1 = maximum; descending reversed.
//    Direction applied by inverting the final-merge orientation per vector, not by a reversal mux.
//  - Compare: SIGNED=0 unsigned '>', SIGNED=1 $signed '>'. Equal keys: no swap. Output is the input
//    multiset reordered; no key is dropped, duplicated or altered. Stability not guaranteed.
//  - Flow control: adv = ~out_valid | out_ready. in_ready = adv (combinational, no in_valid dependency).
//  - When adv=1 every stage loads from its predecessor; stage 0 loads {in_valid, in_desc, in_tag, data_in}.
//    When adv=0 all stages hold. Handshake occurs when in_valid & in_ready.
//  - Latency: S cycles from input handshake to out_valid with out_ready held 1; throughput 1 vector/cycle.
//  - Bubbles are not compressed: an invalid slot advances like a valid one.
//  - out_valid, out_tag, data_out come straight from the last stage register (no output logic).
//  - Under out_valid=1 & out_ready=0, data_out/out_tag/out_valid remain stable until accepted.
//  - Simultaneous input and output handshake in one cycle is legal; nothing is lost.
//  - Reset (async assert, sync-safe deassert by upstream): all valid bits -> 0.
//    out_valid=0, in_ready=1 (since out_valid=0), data_out=0, out_tag=0.
//    Data/tag registers also clear to 0. Vectors in flight at reset are discarded, none emitted later.
//  - No internal FSM beyond the shift pipeline; state is the S stage valid bits.
// TESTING
//  1. Default params, data_in elements k = 31-k, in_desc=0, out_ready=1
//     -> after 15 cycles out_valid=1, data_out element k = k.
//  2. Same vector with in_desc=1, tag=0xA5 -> element k = 31-k, out_tag=0xA5.
//     Back-to-back with test 1 -> outputs on consecutive cycles.
//  3. SIGNED=1, W=16, inputs {0x8000,0x7FFF,0xFFFF,0x0000,...}, ascending
//     -> 0x8000 first, 0x7FFF last. SIGNED=0 same input -> 0x0000 first, 0xFFFF last.
//  4. Stream 40 random vectors with random out_ready (50%) and random in_valid
//     -> each output matches a reference sort, tags in order, no loss/duplication, outputs stable during stall.
//  5. All-equal keys 0x1234, and vector with duplicates {3,1,3,1,...} -> equal keys preserved, counts match.
//  6. Assert rst with 5 vectors in flight
//     -> out_valid=0 immediately (async), in_ready=1, no stale vector emitted after release.
//     LOG_N=1 and LOG_N=6 builds pass test 1 with S=1 and S=21.

Source files
------------

// File: rtl/sort_bitonic_pipe_if.sv
// rtl/sort_bitonic_pipe_if.sv - stream handshake bundle for the bitonic sorting pipeline
interface sort_bitonic_pipe_if #(
  parameter int LOG_N = 5,
  parameter int W     = 16,
  parameter int TAG_W = 8
);
  localparam int N = 1 << LOG_N;

  logic               in_valid;
  logic               in_ready;
  logic               in_desc;
  logic [TAG_W-1:0]   in_tag;
  logic [N*W-1:0]     data_in;
  logic               out_valid;
  logic               out_ready;
  logic [TAG_W-1:0]   out_tag;
  logic [N*W-1:0]     data_out;

  modport slave (
    input  in_valid, in_desc, in_tag, data_in, out_ready,
    output in_ready, out_valid, out_tag, data_out
  );

  modport master (
    output in_valid, in_desc, in_tag, data_in, out_ready,
    input  in_ready, out_valid, out_tag, data_out
  );
endinterface

// File: rtl/sort_bitonic_pipe.sv
// rtl/sort_bitonic_pipe.sv - fully pipelined bitonic sorter, one vector per cycle, whole-pipe stall
module sort_bitonic_pipe #(
  parameter int LOG_N  = 5,
  parameter int W      = 16,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  sort_bitonic_pipe_if.slave  bus
);
  localparam int N = 1 << LOG_N;
  localparam int S = LOG_N * (LOG_N + 1) / 2;
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [W-1:0] KEY_BIAS = (SIGNED != 0) ? (W'(1) << (W - 1)) : '0;

  logic             valid_r [S];
  logic             desc_r  [S];
  logic [TAG_W-1:0] tag_r   [S];
  logic [N*W-1:0]   data_r  [S];
  logic [N*W-1:0]   stage_net [S];
  logic             adv;

  assign adv           = ~valid_r[S-1] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_r[S-1];
  assign bus.out_tag   = tag_r[S-1];
  assign bus.data_out  = data_r[S-1];

  always_comb begin
    int i;
    int j;
    int s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic dsc;
    logic dir;
    logic swap;
    i = 0;
    j = 0;
    s = 0;
    a = '0;
    b = '0;
    dsc = 1'b0;
    dir = 1'b0;
    swap = 1'b0;
    for (int t = 0; t < S; t++) stage_net[t] = '0;
    for (int p = 0; p < LOG_N; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (s == 0) begin
          stage_net[s] = bus.data_in;
          dsc = bus.in_desc;
        end else begin
          stage_net[s] = data_r[s-1];
          dsc = desc_r[s-1];
        end
        for (int k = 0; k < N / 2; k++) begin
          i = ((k >> q) << (q + 1)) | (k & ((1 << q) - 1));
          j = i | (1 << q);
          a = stage_net[s][i*W +: W];
          b = stage_net[s][j*W +: W];
          dir = ((i >> (p + 1)) & 1) != 0;
          // Only the final merge sees the per-vector direction; earlier merges just build bitonic runs.
          if (p == LOG_N - 1) dir = dir ^ dsc;
          swap = dir ? ((b ^ KEY_BIAS) > (a ^ KEY_BIAS))
                     : ((a ^ KEY_BIAS) > (b ^ KEY_BIAS));
          if (swap) begin
            stage_net[s][i*W +: W] = b;
            stage_net[s][j*W +: W] = a;
          end
        end
        s = s + 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < S; t++) begin
        valid_r[t] <= 1'b0;
        desc_r[t]  <= 1'b0;
        tag_r[t]   <= '0;
        data_r[t]  <= '0;
      end
    end else if (adv) begin
      valid_r[0] <= bus.in_valid;
      desc_r[0]  <= bus.in_desc;
      tag_r[0]   <= bus.in_tag;
      data_r[0]  <= stage_net[0];
      for (int t = 1; t < S; t++) begin
        valid_r[t] <= valid_r[t-1];
        desc_r[t]  <= desc_r[t-1];
        tag_r[t]   <= tag_r[t-1];
        data_r[t]  <= stage_net[t];
      end
    end
  end
endmodule

// File: tb/tb_sort_bitonic_pipe.sv
// tb/tb_sort_bitonic_pipe.sv - scoreboard bench for unsigned and signed sorter builds
module tb_sort_bitonic_pipe;
  localparam int LOG_N = 5;
  localparam int N     = 32;
  localparam int W     = 16;
  localparam int TAG_W = 8;
  localparam int S     = 15;
  localparam int NW    = N * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic             in_desc   = 1'b0;
  logic             out_ready = 1'b0;
  logic [TAG_W-1:0] in_tag    = '0;
  logic [NW-1:0]    data_in   = '0;

  sort_bitonic_pipe_if #(.LOG_N(LOG_N), .W(W), .TAG_W(TAG_W)) if_u ();
  sort_bitonic_pipe_if #(.LOG_N(LOG_N), .W(W), .TAG_W(TAG_W)) if_s ();

  assign if_u.in_valid  = in_valid;
  assign if_u.in_desc   = in_desc;
  assign if_u.in_tag    = in_tag;
  assign if_u.data_in   = data_in;
  assign if_u.out_ready = out_ready;
  assign if_s.in_valid  = in_valid;
  assign if_s.in_desc   = in_desc;
  assign if_s.in_tag    = in_tag;
  assign if_s.data_in   = data_in;
  assign if_s.out_ready = out_ready;

  sort_bitonic_pipe #(.LOG_N(LOG_N), .W(W), .SIGNED(0), .TAG_W(TAG_W)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (if_u.slave)
  );

  sort_bitonic_pipe #(.LOG_N(LOG_N), .W(W), .SIGNED(1), .TAG_W(TAG_W)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s.slave)
  );

  typedef struct {
    logic [NW-1:0]    eu;
    logic [NW-1:0]    es;
    logic [TAG_W-1:0] tag;
    int               cyc;
    bit               lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic check_eq(input string name, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] ref_sort(input logic [NW-1:0] v, input bit desc, input bit sgn);
    logic [W-1:0] e [N];
    logic [W-1:0] tmp;
    logic [NW-1:0] r;
    bit less;
    for (int k = 0; k < N; k++) e[k] = v[k*W +: W];
    for (int x = 0; x < N - 1; x++) begin
      for (int y = 0; y < N - 1 - x; y++) begin
        less = sgn ? ($signed(e[y+1]) < $signed(e[y])) : (e[y+1] < e[y]);
        if (desc) less = sgn ? ($signed(e[y+1]) > $signed(e[y])) : (e[y+1] > e[y]);
        if (less) begin
          tmp = e[y]; e[y] = e[y+1]; e[y+1] = tmp;
        end
      end
    end
    for (int k = 0; k < N; k++) r[k*W +: W] = e[k];
    return r;
  endfunction

  // One cycle: drive inputs after the falling edge, then score what the coming rising edge will do.
  task automatic step(input bit v, input bit d, input logic [TAG_W-1:0] t, input logic [NW-1:0] din,
                      input bit ordy, input logic [NW-1:0] eu, input logic [NW-1:0] es,
                      input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_desc   = d;
    in_tag    = t;
    data_in   = din;
    out_ready = ordy;
    #1;
    cyc++;
    acc = v && if_u.in_ready;
    if (if_u.out_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", 1, 0);
      end else begin
        e = sb[0];
        check_eq("data_unsigned", if_u.data_out, e.eu);
        check_eq("data_signed", if_s.data_out, e.es);
        check_eq("tag_unsigned", if_u.out_tag, e.tag);
        check_eq("tag_signed", if_s.out_tag, e.tag);
        check_eq("valid_signed", if_s.out_valid, 1);
        if (ordy) begin
          if (e.lat) check_eq("latency", cyc - e.cyc, S);
          void'(sb.pop_front());
        end
      end
    end
    if (acc) begin
      e.eu = eu; e.es = es; e.tag = t; e.cyc = cyc; e.lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic send(input bit d, input logic [TAG_W-1:0] t, input logic [NW-1:0] din,
                      input logic [NW-1:0] eu, input logic [NW-1:0] es, input bit lat, input bit rnd);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 100) begin
      step(1, d, t, din, rnd ? bit'($urandom_range(0, 1)) : 1'b1, eu, es, lat, acc);
      n++;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int c = 0; c < n; c++) step(0, 0, '0, '0, ordy, '0, '0, 0, acc);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      step(0, 0, '0, '0, 1, '0, '0, 0, acc);
      n++;
    end
    check_eq("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [NW-1:0] v, up, dn, eu, es, mask;
    logic [TAG_W-1:0] tg;

    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", if_u.out_valid, 0);
    check_eq("rst_in_ready", if_u.in_ready, 1);
    check_eq("rst_data_out", if_u.data_out, 0);
    check_eq("rst_out_tag", if_u.out_tag, 0);
    rst = 1'b0;

    for (int k = 0; k < N; k++) begin
      v[k*W +: W]  = W'(N - 1 - k);
      up[k*W +: W] = W'(k);
      dn[k*W +: W] = W'(N - 1 - k);
    end
    send(0, 8'h11, v, up, up, 1, 0);
    send(1, 8'hA5, v, dn, dn, 1, 0);
    drain();

    v  = '0;
    v[0*W +: W] = 16'h8000;
    v[1*W +: W] = 16'h7FFF;
    v[2*W +: W] = 16'hFFFF;
    v[3*W +: W] = 16'h0000;
    for (int k = 4; k < N; k++) v[k*W +: W] = W'(k * 100);
    eu = '0;
    es = '0;
    eu[0*W +: W] = 16'h0000;
    es[0*W +: W] = 16'h8000;
    es[1*W +: W] = 16'hFFFF;
    es[2*W +: W] = 16'h0000;
    for (int k = 4; k < N; k++) begin
      eu[(k-3)*W +: W] = W'(k * 100);
      es[(k-1)*W +: W] = W'(k * 100);
    end
    eu[29*W +: W] = 16'h7FFF;
    eu[30*W +: W] = 16'h8000;
    eu[31*W +: W] = 16'hFFFF;
    es[31*W +: W] = 16'h7FFF;
    send(0, 8'h33, v, eu, es, 0, 0);

    for (int k = 0; k < N; k++) v[k*W +: W] = 16'h1234;
    send(1, 8'h55, v, v, v, 0, 0);
    for (int k = 0; k < N; k++) v[k*W +: W] = (k % 2 == 0) ? W'(3) : W'(1);
    send(0, 8'h56, v, ref_sort(v, 0, 0), ref_sort(v, 0, 1), 0, 0);
    send(1, 8'h57, v, ref_sort(v, 1, 0), ref_sort(v, 1, 1), 0, 0);
    drain();

    for (int r = 0; r < 40; r++) begin
      mask = (r % 2 == 0) ? {N{16'hFFFF}} : {N{16'h0007}};
      for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom) & mask[k*W +: W];
      tg = TAG_W'(8'h40 + r);
      idle($urandom_range(0, 2), bit'($urandom_range(0, 1)));
      send(r % 3 == 1, tg, v, ref_sort(v, r % 3 == 1, 0), ref_sort(v, r % 3 == 1, 1), 0, 1);
    end
    drain();

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
      send(0, TAG_W'(8'h80 + r), v, ref_sort(v, 0, 0), ref_sort(v, 0, 1), 0, 0);
    end
    idle(20, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_out_valid", if_u.out_valid, 0);
    check_eq("async_in_ready", if_u.in_ready, 1);
    check_eq("async_data_out", if_u.data_out, 0);
    check_eq("async_out_tag", if_u.out_tag, 0);
    check_eq("async_valid_signed", if_s.out_valid, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(30, 1);

    for (int k = 0; k < N; k++) v[k*W +: W] = W'(N - 1 - k);
    send(0, 8'h99, v, up, up, 1, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
